// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD stopwatch core fed by the 1 Hz 'seconds' square wave.
//   Counts elapsed time while running. Supports pause/run, a synchronous clear, and a
//   field-adjust mode that steps the minutes or seconds field at 2 Hz.
// Ports:
//   clk, reset (async, active-low)
//   seconds   - divider square wave (1 while the divider is in reset)
//   pause_btn - debounced level; each rising edge toggles run/pause
//   adj, sel  - adjust mode enable; field select (0 = minutes, 1 = seconds)
//   clr       - synchronous clear of all digits; FSM state is kept
//   min_tens, min_ones, sec_tens, sec_ones - BCD digits
//   paused    - FSM is in PAUSED
//   blink     - follows 'seconds' in ADJUST so the display can blank the field; else 0
module stopwatch_counter #(
  parameter int unsigned MIN_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seconds,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  input  logic       clr,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused,
  output logic       blink
);

  typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_t;

  state_t     state, state_nxt;
  logic       seconds_q, pause_q;
  logic       tick_r_q, tick_a_q, pause_e_q;
  logic       run_inc, adj_inc_min, adj_inc_sec, sec_carry;
  logic [2:0] min_tens_nxt, sec_tens_nxt;
  logic [3:0] min_ones_nxt, sec_ones_nxt;

  // Registered edge detectors; seconds_q resets to 1 so release never fakes a tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seconds_q <= 1'b1;
      pause_q   <= 1'b0;
      tick_r_q  <= 1'b0;
      tick_a_q  <= 1'b0;
      pause_e_q <= 1'b0;
    end else begin
      seconds_q <= seconds;
      pause_q   <= pause_btn;
      tick_r_q  <= seconds & ~seconds_q;
      tick_a_q  <= seconds ^ seconds_q;
      pause_e_q <= pause_btn & ~pause_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PAUSED;
    else        state <= state_nxt;
  end

  // Next-state logic; adj overrides everything, pause edges ignored in ADJUST.
  always_comb begin
    state_nxt = state;
    unique case (state)
      PAUSED:  if (pause_e_q) state_nxt = RUN;
      RUN:     if (pause_e_q) state_nxt = PAUSED;
      ADJUST:  if (!adj)      state_nxt = PAUSED;
      default: state_nxt = PAUSED;
    endcase
    if (adj) state_nxt = ADJUST;
  end

  // Increment enables; a run tick coinciding with entry into ADJUST is dropped.
  always_comb begin
    run_inc     = (state == RUN) && !adj && tick_r_q;
    adj_inc_min = (state == ADJUST) && adj && tick_a_q && !sel;
    adj_inc_sec = (state == ADJUST) && adj && tick_a_q && sel;
    sec_carry   = run_inc && (sec_ones >= 4'd9) && (sec_tens >= 3'd5);
  end

  // BCD digit chain; seconds carry into minutes only when running.
  always_comb begin
    min_tens_nxt = min_tens;
    min_ones_nxt = min_ones;
    sec_tens_nxt = sec_tens;
    sec_ones_nxt = sec_ones;
    if (clr) begin
      min_tens_nxt = 3'd0;
      min_ones_nxt = 4'd0;
      sec_tens_nxt = 3'd0;
      sec_ones_nxt = 4'd0;
    end else begin
      if (run_inc || adj_inc_sec) begin
        if (sec_ones >= 4'd9) begin
          sec_ones_nxt = 4'd0;
          sec_tens_nxt = (sec_tens >= 3'd5) ? 3'd0 : sec_tens + 3'd1;
        end else begin
          sec_ones_nxt = sec_ones + 4'd1;
        end
      end
      if (sec_carry || adj_inc_min) begin
        if (min_ones >= 4'd9) begin
          min_ones_nxt = 4'd0;
          min_tens_nxt = (min_tens >= 3'(MIN_TENS_MAX)) ? 3'd0 : min_tens + 3'd1;
        end else begin
          min_ones_nxt = min_ones + 4'd1;
        end
      end
    end
  end

  // Digit and status output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_tens <= 3'd0;
      min_ones <= 4'd0;
      sec_tens <= 3'd0;
      sec_ones <= 4'd0;
      paused   <= 1'b1;
      blink    <= 1'b0;
    end else begin
      min_tens <= min_tens_nxt;
      min_ones <= min_ones_nxt;
      sec_tens <= sec_tens_nxt;
      sec_ones <= sec_ones_nxt;
      paused   <= (state_nxt == PAUSED);
      blink    <= (state_nxt == ADJUST) && seconds;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter (MIN_TENS_MAX = 5).
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       reset, seconds, pause_btn, adj, sel, clr;
  logic [2:0] min_tens, sec_tens;
  logic [3:0] min_ones, sec_ones;
  logic       paused, blink;
  int         errors = 0;
  int         checks = 0;

  stopwatch_counter #(.MIN_TENS_MAX(5)) dut (
    .clk(clk), .reset(reset), .seconds(seconds), .pause_btn(pause_btn),
    .adj(adj), .sel(sel), .clr(clr),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .paused(paused), .blink(blink)
  );

  always #5 clk = ~clk;

  // Display as 16'hMMSS nibbles
  function automatic logic [15:0] disp();
    return {1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tog();
    seconds = ~seconds;
    step(3);
  endtask

  // One full period of the square wave: exactly one rising edge
  task automatic sec_pulse();
    tog();
    tog();
  endtask

  task automatic press();
    pause_btn = 1'b1;
    step(1);
    pause_btn = 1'b0;
    step(2);
  endtask

  task automatic sec_low();
    if (seconds) tog();
  endtask

  initial begin
    reset = 1'b0; seconds = 1'b1; pause_btn = 1'b0;
    adj = 1'b0; sel = 1'b0; clr = 1'b0;
    step(2);
    check("reset_digits", disp(), 16'h0000);
    check("reset_paused", {15'd0, paused}, 16'd1);
    check("reset_blink", {15'd0, blink}, 16'd0);
    reset = 1'b1;
    step(2);

    // Run up to 00:37, then reset between edges
    press();
    repeat (37) sec_pulse();
    check("run_0037", disp(), 16'h0037);
    check("run_paused", {15'd0, paused}, 16'd0);
    #2 reset = 1'b0;
    seconds = 1'b1;
    #1;
    check("async_reset_digits", disp(), 16'h0000);
    check("async_reset_paused", {15'd0, paused}, 16'd1);
    step(2);
    reset = 1'b1;
    step(1);
    repeat (3) sec_pulse();
    check("post_reset_hold", disp(), 16'h0000);

    // Start and count 10 seconds
    press();
    check("press_run", {15'd0, paused}, 16'd0);
    repeat (10) sec_pulse();
    check("count_0010", disp(), 16'h0010);

    // Adjust to 59:58
    adj = 1'b1; sel = 1'b0;
    step(2);
    check("adj_paused", {15'd0, paused}, 16'd0);
    repeat (59) tog();
    check("adj_min_59", disp(), 16'h5910);
    check("blink_follow", {15'd0, blink}, {15'd0, seconds});
    sel = 1'b1;
    repeat (48) tog();
    check("adj_5958", disp(), 16'h5958);
    adj = 1'b0;
    step(2);
    check("adj_exit_paused", {15'd0, paused}, 16'd1);
    check("adj_exit_blink", {15'd0, blink}, 16'd0);
    press();
    sec_pulse();
    check("run_5959", disp(), 16'h5959);
    sec_pulse();
    check("wrap_0000", disp(), 16'h0000);

    // Adjust from 00:59: minutes +3, then seconds wraps without carry
    adj = 1'b1; sel = 1'b1;
    step(2);
    repeat (59) tog();
    check("adj_0059", disp(), 16'h0059);
    sel = 1'b0;
    repeat (3) tog();
    check("adj_0359", disp(), 16'h0359);
    sel = 1'b1;
    tog();
    check("adj_sec_wrap", disp(), 16'h0300);

    // Set 12:34 then clear coincident with a run tick
    sel = 1'b0;
    repeat (9) tog();
    sel = 1'b1;
    repeat (34) tog();
    check("adj_1234", disp(), 16'h1234);
    adj = 1'b0;
    step(2);
    press();
    sec_low();
    seconds = 1'b1; clr = 1'b1;
    step(3);
    clr = 1'b0;
    check("clr_tick", disp(), 16'h0000);
    check("clr_run", {15'd0, paused}, 16'd0);

    // Pause edge coincident with a tick at 00:05
    repeat (5) sec_pulse();
    check("run_0005", disp(), 16'h0005);
    sec_low();
    seconds = 1'b1; pause_btn = 1'b1;
    step(3);
    pause_btn = 1'b0;
    check("pause_tick_count", disp(), 16'h0006);
    check("pause_tick_paused", {15'd0, paused}, 16'd1);
    repeat (2) sec_pulse();
    check("paused_hold", disp(), 16'h0006);

    // adj asserted on the same cycle a run tick is applied: tick dropped
    press();
    sec_low();
    seconds = 1'b1;
    step(1);
    adj = 1'b1;
    step(3);
    check("adj_drops_tick", disp(), 16'h0006);
    check("adj_not_paused", {15'd0, paused}, 16'd0);
    adj = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
